clock_gate_ctrl: RTL and testbench

- Initiator side of the core clock-gate handshake.
- Accepts an IDLE request from the core and waits for the pipeline and bus to drain.
- Raises clear_clock_gate to pause the gated core clock, watches wake sources, then pulses set_clock_gate to resume.
- Runs entirely on the ungated aclk and drives the clear_clock_gate/set_clock_gate inputs of clock_gate.

---
 rtl/clk_ctrl_pkg.sv | 17 +
 rtl/ctrl_down_counter.sv | 29 ++
 rtl/clock_gate_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clock_gate_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clock-gate initiator.
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        StRun,
        StDrain,
        StGate,
        StSleep,
        StWake,
        StResume
    } ctrl_state_e;

    localparam int unsigned WC_INT = 0;
    localparam int unsigned WC_DBG = 1;
    localparam int unsigned CNT_W  = 16;

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable down-counter with a zero flag; it holds at zero rather than wrapping.
module ctrl_down_counter
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         aclk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clock_gate_ctrl.sv
// Initiator side of the core clock-gate handshake: drains the core on IDLE, pauses the
// gated clock via clear_clock_gate, waits for a wake source and resumes via set_clock_gate.
module clock_gate_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned INT_W      = 8,
    parameter int unsigned DRAIN_MAX  = 255,
    parameter int unsigned MIN_SLEEP  = 2,
    parameter int unsigned WAKE_DELAY = 3
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic             idle_req_i,
    input  logic             pipe_empty_i,
    input  logic             bus_idle_i,
    input  logic [INT_W-1:0] int_pending_i,
    input  logic [INT_W-1:0] int_enable_i,
    input  logic             debug_req_i,
    output logic             clear_clock_gate_o,
    output logic             set_clock_gate_o,
    output logic             sleeping_o,
    output logic             wake_valid_o,
    output logic [1:0]       wake_cause_o,
    output logic             idle_abort_o,
    output logic [31:0]      sleep_cycles_o
);

    ctrl_state_e state_q;
    logic        clear_q, set_q, sleeping_q, wake_valid_q, idle_abort_q;
    logic [1:0]  wake_cause_q, cause_q, pend_q;
    logic [31:0] sleep_cycles_q;

    logic             wk, drain_ready, cnt_zero, cnt_load, cnt_dec;
    logic [1:0]       cause, sleep_cause;
    logic [CNT_W-1:0] cnt_val;

    always_comb begin
        cause         = '0;
        cause[WC_INT] = |(int_pending_i & int_enable_i);
        cause[WC_DBG] = debug_req_i;
        wk            = |cause;
        drain_ready   = pipe_empty_i & bus_idle_i;
        // Early wake sources seen during the minimum sleep stay pending until it expires.
        sleep_cause   = cause | pend_q;
    end

    // One counter serves drain timeout, minimum sleep and wake delay; only one is live per state.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            StRun: begin
                cnt_load = idle_req_i;
                cnt_val  = CNT_W'(DRAIN_MAX);
            end
            StDrain:  cnt_dec = !wk && !drain_ready;
            StGate: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(MIN_SLEEP - 1);
            end
            StSleep:  cnt_dec = 1'b1;
            StWake: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(WAKE_DELAY - 1);
            end
            StResume: cnt_dec = 1'b1;
            default: begin
                cnt_load = 1'b0;
                cnt_dec  = 1'b0;
            end
        endcase
    end

    ctrl_down_counter #(
        .W (CNT_W)
    ) u_cnt (
        .aclk       (aclk),
        .resetn     (resetn),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q        <= StRun;
            clear_q        <= 1'b0;
            set_q          <= 1'b0;
            sleeping_q     <= 1'b0;
            wake_valid_q   <= 1'b0;
            wake_cause_q   <= '0;
            idle_abort_q   <= 1'b0;
            sleep_cycles_q <= '0;
            cause_q        <= '0;
            pend_q         <= '0;
        end else begin
            wake_valid_q <= 1'b0;
            idle_abort_q <= 1'b0;
            set_q        <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (idle_req_i) state_q <= StDrain;
                end
                StDrain: begin
                    if (wk) begin
                        state_q      <= StRun;
                        wake_valid_q <= 1'b1;
                        wake_cause_q <= cause;
                    end else if (drain_ready) begin
                        state_q <= StGate;
                    end else if (cnt_zero) begin
                        state_q      <= StRun;
                        idle_abort_q <= 1'b1;
                        wake_valid_q <= 1'b1;
                        wake_cause_q <= '0;
                    end
                end
                StGate: begin
                    clear_q    <= 1'b1;
                    sleeping_q <= 1'b1;
                    pend_q     <= '0;
                    state_q    <= StSleep;
                end
                StSleep: begin
                    if (sleep_cycles_q != '1) sleep_cycles_q <= sleep_cycles_q + 32'd1;
                    pend_q <= sleep_cause;
                    if (cnt_zero && (|sleep_cause)) begin
                        cause_q <= sleep_cause;
                        state_q <= StWake;
                    end
                end
                StWake: begin
                    set_q   <= 1'b1;
                    clear_q <= 1'b0;
                    state_q <= StResume;
                end
                StResume: begin
                    if (cnt_zero) begin
                        wake_valid_q <= 1'b1;
                        wake_cause_q <= cause_q;
                        sleeping_q   <= 1'b0;
                        state_q      <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign clear_clock_gate_o = clear_q;
    assign set_clock_gate_o   = set_q;
    assign sleeping_o         = sleeping_q;
    assign wake_valid_o       = wake_valid_q;
    assign wake_cause_o       = wake_cause_q;
    assign idle_abort_o       = idle_abort_q;
    assign sleep_cycles_o     = sleep_cycles_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl with a small gate model and handshake invariant checks.
module tb_clock_gate_ctrl;

    localparam int unsigned INT_W = 8;

    logic             aclk = 1'b0;
    logic             resetn = 1'b0;
    logic             idle_req = 1'b0;
    logic             pipe_empty = 1'b0;
    logic             bus_idle = 1'b0;
    logic             debug_req = 1'b0;
    logic [INT_W-1:0] int_pending = '0;
    logic [INT_W-1:0] int_enable = '0;
    logic             clear_o, set_o, sleeping_o, wake_valid_o, idle_abort_o;
    logic [1:0]       wake_cause_o;
    logic [31:0]      sleep_cycles_o;

    int vectors = 0;
    int miscompares = 0;

    clock_gate_ctrl #(
        .INT_W      (INT_W),
        .DRAIN_MAX  (4),
        .MIN_SLEEP  (2),
        .WAKE_DELAY (3)
    ) dut (
        .aclk               (aclk),
        .resetn             (resetn),
        .idle_req_i         (idle_req),
        .pipe_empty_i       (pipe_empty),
        .bus_idle_i         (bus_idle),
        .int_pending_i      (int_pending),
        .int_enable_i       (int_enable),
        .debug_req_i        (debug_req),
        .clear_clock_gate_o (clear_o),
        .set_clock_gate_o   (set_o),
        .sleeping_o         (sleeping_o),
        .wake_valid_o       (wake_valid_o),
        .wake_cause_o       (wake_cause_o),
        .idle_abort_o       (idle_abort_o),
        .sleep_cycles_o     (sleep_cycles_o)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gate model (clear edge wins over set) and protocol invariants, sampled mid-cycle.
    logic clear_prev = 1'b0;
    logic rose_prev = 1'b0;
    logic paused = 1'b0;
    int   both_cnt = 0;
    int   rises = 0;

    always @(negedge aclk) begin : mon
        logic rose_now;
        if (!resetn) begin
            clear_prev <= 1'b0;
            rose_prev  <= 1'b0;
            paused     <= 1'b0;
            both_cnt   <= 0;
            rises      <= 0;
        end else begin
            rose_now = clear_o && !clear_prev;
            vectors += 3;
            assert (!(set_o && (rose_now || rose_prev))) else begin
                miscompares++;
                $error("FAIL set_near_clear_rise: observed set=%0b expected 0", set_o);
            end
            assert (!(set_o && clear_o && both_cnt >= 1)) else begin
                miscompares++;
                $error("FAIL set_clear_overlap: observed %0d extra cycles expected 0", both_cnt);
            end
            assert (!(rose_now && rises >= 1)) else begin
                miscompares++;
                $error("FAIL double_clear_rise: observed %0d prior rises expected 0", rises);
            end
            clear_prev <= clear_o;
            rose_prev  <= rose_now;
            both_cnt   <= (set_o && clear_o) ? both_cnt + 1 : 0;
            if (wake_valid_o) rises <= 0;
            else if (rose_now) rises <= rises + 1;
            if (rose_now) paused <= 1'b1;
            else if (set_o) paused <= 1'b0;
        end
    end

    initial begin
        // Reset state
        step();
        step();
        chk("rst_clear", clear_o, 0);
        chk("rst_set", set_o, 0);
        chk("rst_sleeping", sleeping_o, 0);
        chk("rst_wake_valid", wake_valid_o, 0);
        chk("rst_wake_cause", wake_cause_o, 0);
        chk("rst_idle_abort", idle_abort_o, 0);
        chk("rst_sleep_cycles", sleep_cycles_o, 0);
        resetn = 1'b1;
        step();

        // Basic sleep/wake: interrupt 10 cycles after clear rises
        pipe_empty = 1'b1;
        bus_idle   = 1'b1;
        idle_req   = 1'b1;
        step();
        idle_req = 1'b0;
        chk("t1_clear_drain", clear_o, 0);
        step();
        chk("t1_clear_gate", clear_o, 0);
        step();
        chk("t1_clear_rise", clear_o, 1);
        chk("t1_sleeping", sleeping_o, 1);
        for (int i = 0; i < 10; i++) step();
        int_pending = 8'h04;
        int_enable  = 8'h04;
        step();
        chk("t1_set_wake", set_o, 0);
        chk("t1_clear_wake", clear_o, 1);
        step();
        chk("t1_set_pulse", set_o, 1);
        chk("t1_clear_drop", clear_o, 0);
        chk("t1_sleep_cycles", sleep_cycles_o, 11);
        int_pending = '0;
        int_enable  = '0;
        step();
        chk("t1_set_one_cycle", set_o, 0);
        chk("t1_wv_early1", wake_valid_o, 0);
        step();
        chk("t1_wv_early2", wake_valid_o, 0);
        step();
        chk("t1_wv", wake_valid_o, 1);
        chk("t1_cause", wake_cause_o, 2'b01);
        chk("t1_sleeping_off", sleeping_o, 0);
        chk("t1_no_abort", idle_abort_o, 0);
        step();
        chk("t1_wv_pulse", wake_valid_o, 0);
        chk("t1_cause_held", wake_cause_o, 2'b01);

        // Pending debug during drain, idle_req coincident with wk
        debug_req  = 1'b1;
        pipe_empty = 1'b0;
        idle_req   = 1'b1;
        step();
        idle_req = 1'b0;
        chk("t2_wv_early", wake_valid_o, 0);
        step();
        chk("t2_wv", wake_valid_o, 1);
        chk("t2_cause", wake_cause_o, 2'b10);
        chk("t2_clear", clear_o, 0);
        step();
        chk("t2_wv_pulse", wake_valid_o, 0);
        chk("t2_cause_held", wake_cause_o, 2'b10);
        chk("t2_clear_after", clear_o, 0);
        debug_req = 1'b0;

        // Drain timeout with DRAIN_MAX=4
        pipe_empty = 1'b1;
        bus_idle   = 1'b0;
        idle_req   = 1'b1;
        step();
        idle_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t3_abort_early", idle_abort_o, 0);
        chk("t3_wv_early", wake_valid_o, 0);
        step();
        chk("t3_abort", idle_abort_o, 1);
        chk("t3_wv", wake_valid_o, 1);
        chk("t3_cause", wake_cause_o, 0);
        chk("t3_clear", clear_o, 0);
        step();
        chk("t3_abort_pulse", idle_abort_o, 0);

        // Early wake source present in the GATE cycle
        bus_idle = 1'b1;
        idle_req = 1'b1;
        step();
        idle_req = 1'b0;
        step();
        int_pending = 8'h10;
        int_enable  = 8'h30;
        step();
        chk("t4_clear_rise", clear_o, 1);
        chk("t4_set_c0", set_o, 0);
        step();
        chk("t4_set_c1", set_o, 0);
        chk("t4_paused", paused, 1);
        step();
        chk("t4_set_c2", set_o, 0);
        step();
        chk("t4_set_c3", set_o, 1);
        chk("t4_sleep_cycles", sleep_cycles_o, 13);
        int_pending = '0;
        int_enable  = '0;
        step();
        chk("t4_unpaused", paused, 0);
        step();
        step();
        chk("t4_wv", wake_valid_o, 1);
        chk("t4_cause", wake_cause_o, 2'b01);

        // Masked interrupts keep the core asleep until enabled
        int_pending = 8'hFF;
        int_enable  = 8'h00;
        idle_req    = 1'b1;
        step();
        idle_req = 1'b0;
        step();
        step();
        chk("t5_clear_rise", clear_o, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_masked_set", set_o, 0);
            chk("t5_masked_sleeping", sleeping_o, 1);
        end
        int_enable = 8'h01;
        step();
        step();
        chk("t5_set", set_o, 1);
        chk("t5_sleep_cycles", sleep_cycles_o, 34);
        int_pending = '0;
        int_enable  = '0;
        step();
        step();
        step();
        chk("t5_wv", wake_valid_o, 1);
        chk("t5_cause", wake_cause_o, 2'b01);

        // Reset in the middle of SLEEP, then a normal sleep
        idle_req = 1'b1;
        step();
        idle_req = 1'b0;
        step();
        step();
        chk("t6_clear_rise", clear_o, 1);
        step();
        step();
        resetn = 1'b0;
        step();
        chk("t6_rst_clear", clear_o, 0);
        chk("t6_rst_sleeping", sleeping_o, 0);
        chk("t6_rst_sleep_cycles", sleep_cycles_o, 0);
        chk("t6_rst_cause", wake_cause_o, 0);
        chk("t6_rst_paused", paused, 0);
        resetn = 1'b1;
        step();
        idle_req = 1'b1;
        step();
        idle_req = 1'b0;
        step();
        step();
        chk("t6_clear_again", clear_o, 1);
        chk("t6_sleeping_again", sleeping_o, 1);
        debug_req = 1'b1;
        step();
        step();
        step();
        chk("t6_set", set_o, 1);
        chk("t6_sleep_cycles", sleep_cycles_o, 2);
        debug_req = 1'b0;
        step();
        step();
        step();
        chk("t6_wv", wake_valid_o, 1);
        chk("t6_cause", wake_cause_o, 2'b10);
        chk("t6_sleeping_off", sleeping_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
